wb_trace_checker: RTL
=====================

Name: wb_trace_checker

Overview:
- Consumer end of the CPU writeback debug-trace interface (debug_wb_have_inst/pc/ena/reg/value).
- Walks a golden trace held in a combinational-read trace ROM.
- Compares each retired instruction against the next golden record; latches PASS or FAIL plus first-failure diagnostics.
- Sits in the SoC beside the CPU core for automated trace testing.

Parameters:
- AW, 16, trace ROM address width; capacity 2^AW records.
- TIMEOUT, 1024, maximum consecutive cycles without debug_wb_have_inst before failure (≥2).
- END_PC, 32'hFFFF_FFFF, golden-record PC value that marks end of trace.

Ports:
- cpu_clk  in  1  sole clock; all state on rising edge.
- cpu_rst  in  1  synchronous, active-high reset.
- debug_wb_have_inst  in  1  an instruction retires this cycle.
- debug_wb_pc  in  32  PC of the retiring instruction.
- debug_wb_ena  in  1  register-file write enable.
- debug_wb_reg  in  5  destination register.
- debug_wb_value  in  32  writeback value.
- trace_addr  out  AW  golden ROM address; equals the record pointer.
- trace_data  in  70  golden record, same cycle: [69] ena, [68:64] reg, [63:32] pc, [31:0] value.
- done  out  1  checking finished (PASS or FAIL).
- pass  out  1  trace matched to end marker.
- fail  out  1  failure detected.
- fail_cause  out  2  0 none, 1 mismatch, 2 timeout, 3 overrun.
- fail_index  out  AW  record pointer at failure.
- fail_pc  out  32  actual PC at failure (0 for timeout).
- fail_exp_value  out  32  golden value at failure.
- fail_act_value  out  32  actual value at failure.
- inst_count  out  32  number of matched instructions.

Behaviour:
- Reset (cpu_rst=1 at edge): state RUN, pointer 0, timeout counter 0, inst_count 0. done/pass/fail 0, fail_cause 0, all fail_* 0. Reset mid-run aborts and restarts from record 0.
- States: RUN, PASS, FAIL. PASS and FAIL are absorbing until reset; in them, inputs are ignored and all outputs hold.
- End marker: in RUN, if trace_data[63:32]==END_PC, go to PASS next edge. Takes priority over a same-cycle have_inst, which is ignored (not counted, not failed).
- Normalisation: a write is effective iff ena=1 and reg≠0, applied to both the actual and golden sides.
- Match: pc equal, effective-write flags equal, and when effective, reg equal and value equal. Value and reg are don't-care when no effective write.
- RUN, have_inst=1, not end marker:
  - Match: pointer+1, inst_count+1, timeout counter cleared.
  - Mismatch: go to FAIL with cause 1; latch pointer, actual pc, golden value, actual value.
- Overrun: a match with pointer==2^AW-1 goes to FAIL cause 3 instead of wrapping; latch as for mismatch. inst_count still increments.
- Timeout: in RUN with have_inst=0, counter increments. When the counter equals TIMEOUT-1 with have_inst=0, go to FAIL cause 2 next edge; fail_pc=0, fail_exp_value=golden value, fail_act_value=0.
- Outputs: all registered. done=pass|fail; pass and fail are never both 1. Diagnostics are updated only on the RUN→FAIL transition (first failure wins).
- Latency: a result is visible one cycle after the deciding input cycle.
- Widths: inst_count saturates at 32'hFFFF_FFFF. Timeout counter width is $clog2(TIMEOUT)+1.

Decomposition:
- Shared package: record field bit positions, record width 70, fail_cause constants (CAUSE_NONE/MISMATCH/TIMEOUT/OVERRUN), state enum.
- One sub-module: wb_trace_compare, purely combinational record-vs-actual comparison with normalisation, output match.
- Top level holds the FSM, pointer, counters and diagnostic latches.

Test Plan:
- 3 golden records (pc 0x0, 0x4, 0x8 with writes x1=5, x2=7, none), then END_PC; drive matching have_inst on 3 cycles -> pass=1 one cycle after the end marker is addressed, inst_count=3, fail_cause=0.
- Record 1 expects x2=7, CPU drives x2=8 -> fail=1, cause=1, fail_index=1, fail_pc=0x4, fail_exp_value=7, fail_act_value=8, inst_count=1.
- Golden ena=1 reg=0 value=0x55 vs actual ena=0 value=0x99 at the same pc -> treated as match, pointer advances.
- TIMEOUT=8, no have_inst after reset -> fail asserts on the edge after the 8th idle cycle, cause=2, fail_pc=0.
- AW=2, 4 matching records, no end marker -> 4th match gives fail cause=3, fail_index=3, inst_count=4.
- Assert cpu_rst mid-run after 2 matches, then replay the trace -> pointer and inst_count restart at 0 and the trace passes.

Source files
------------

// File: rtl/wb_trace_checker_pkg.sv
// wb_trace_checker_pkg: shared record layout, failure causes and checker states
package wb_trace_checker_pkg;
  localparam int REC_W = 70;
  localparam int REC_ENA = 69;
  localparam int REC_REG_HI = 68;
  localparam int REC_REG_LO = 64;
  localparam int REC_PC_HI = 63;
  localparam int REC_PC_LO = 32;
  localparam int REC_VAL_HI = 31;
  localparam int REC_VAL_LO = 0;
  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_MISMATCH = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
  localparam logic [1:0] CAUSE_OVERRUN = 2'd3;
  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL} state_e;
endpackage

// File: rtl/wb_trace_checker_if.sv
// wb_trace_checker_if: CPU writeback debug-trace bus
interface wb_trace_checker_if;
  logic debug_wb_have_inst;
  logic [31:0] debug_wb_pc;
  logic debug_wb_ena;
  logic [4:0] debug_wb_reg;
  logic [31:0] debug_wb_value;
  modport master (output debug_wb_have_inst, debug_wb_pc, debug_wb_ena, debug_wb_reg, debug_wb_value);
  modport slave (input debug_wb_have_inst, debug_wb_pc, debug_wb_ena, debug_wb_reg, debug_wb_value);
endinterface

// File: rtl/wb_trace_compare.sv
// wb_trace_compare: golden record vs retired instruction, writes to x0 count as no write
module wb_trace_compare
  import wb_trace_checker_pkg::*;
(
  input  logic [REC_W-1:0] rec_i,
  input  logic             ena_i,
  input  logic [4:0]       reg_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      value_i,
  output logic             match_o
);
  logic g_eff, a_eff;
  always_comb begin
    g_eff = rec_i[REC_ENA] && (rec_i[REC_REG_HI:REC_REG_LO] != 5'd0);
    a_eff = ena_i && (reg_i != 5'd0);
    match_o = (rec_i[REC_PC_HI:REC_PC_LO] == pc_i) && (g_eff == a_eff) &&
              (!g_eff || ((rec_i[REC_REG_HI:REC_REG_LO] == reg_i) && (rec_i[REC_VAL_HI:REC_VAL_LO] == value_i)));
  end
endmodule

// File: rtl/wb_trace_checker.sv
// wb_trace_checker: walks a golden trace ROM against retired instructions, latching PASS/FAIL and first-failure diagnostics
module wb_trace_checker
  import wb_trace_checker_pkg::*;
#(
  parameter int          AW = 16,
  parameter int          TIMEOUT = 1024,
  parameter logic [31:0] END_PC = 32'hFFFF_FFFF
) (
  input  logic                cpu_clk,
  input  logic                cpu_rst,
  wb_trace_checker_if.slave   wb,
  output logic [AW-1:0]       trace_addr,
  input  logic [REC_W-1:0]    trace_data,
  output logic                done,
  output logic                pass,
  output logic                fail,
  output logic [1:0]          fail_cause,
  output logic [AW-1:0]       fail_index,
  output logic [31:0]         fail_pc,
  output logic [31:0]         fail_exp_value,
  output logic [31:0]         fail_act_value,
  output logic [31:0]         inst_count
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  state_e state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d, idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] count_q, count_d, pc_q, pc_d, exp_q, exp_d, act_q, act_d;
  logic [1:0] cause_q, cause_d;
  logic match, is_end, run, have, idle, last, to_fail;
  wb_trace_compare u_cmp (
    .rec_i   (trace_data),
    .ena_i   (wb.debug_wb_ena),
    .reg_i   (wb.debug_wb_reg),
    .pc_i    (wb.debug_wb_pc),
    .value_i (wb.debug_wb_value),
    .match_o (match)
  );
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q <= S_RUN;
      ptr_q <= '0;
      cnt_q <= '0;
      count_q <= '0;
      cause_q <= CAUSE_NONE;
      idx_q <= '0;
      pc_q <= '0;
      exp_q <= '0;
      act_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      count_q <= count_d;
      cause_q <= cause_d;
      idx_q <= idx_d;
      pc_q <= pc_d;
      exp_q <= exp_d;
      act_q <= act_d;
    end
  end
  // End marker outranks a same-cycle retirement; the last record never wraps
  always_comb begin
    is_end = trace_data[REC_PC_HI:REC_PC_LO] == END_PC;
    last = ptr_q == {AW{1'b1}};
    state_d = state_q;
    if (state_q == S_RUN) begin
      if (is_end) state_d = S_PASS;
      else if (wb.debug_wb_have_inst) state_d = (!match || last) ? S_FAIL : S_RUN;
      else if (cnt_q == CW'(TIMEOUT - 1)) state_d = S_FAIL;
    end
  end
  always_comb begin
    run = state_q == S_RUN;
    have = run && !is_end && wb.debug_wb_have_inst;
    idle = run && !is_end && !wb.debug_wb_have_inst;
    to_fail = run && (state_d == S_FAIL);
    ptr_d = (have && match && !last) ? ptr_q + 1'b1 : ptr_q;
    cnt_d = have ? '0 : idle ? cnt_q + 1'b1 : cnt_q;
    count_d = (have && match && count_q != 32'hFFFF_FFFF) ? count_q + 32'd1 : count_q;
    cause_d = !to_fail ? cause_q : !have ? CAUSE_TIMEOUT : !match ? CAUSE_MISMATCH : CAUSE_OVERRUN;
    idx_d = to_fail ? ptr_q : idx_q;
    pc_d = to_fail ? (have ? wb.debug_wb_pc : 32'd0) : pc_q;
    exp_d = to_fail ? trace_data[REC_VAL_HI:REC_VAL_LO] : exp_q;
    act_d = to_fail ? (have ? wb.debug_wb_value : 32'd0) : act_q;
    trace_addr = ptr_q;
    pass = state_q == S_PASS;
    fail = state_q == S_FAIL;
    done = pass || fail;
    fail_cause = cause_q;
    fail_index = idx_q;
    fail_pc = pc_q;
    fail_exp_value = exp_q;
    fail_act_value = act_q;
    inst_count = count_q;
  end
endmodule
